dm_arbiter: RTL and testbench

Two-port arbiter placing the single-cycle CPU and a word-wide DMA/debug-loader port in front of the one data memory `dm`. The arbiter sits between `sccpu` and `dm` inside the top level. The CPU is the default owner with zero-latency pass-through. The DMA port is granted on idle CPU cycles, or forcibly after a starvation limit, and the CPU is stalled while the DMA port holds the memory. `dm` reads are combinational and writes commit on the `clk` rising edge.

---
 rtl/dm_arb_pkg.sv | 13 +
 rtl/dm_arbiter.sv | 113 +++++++++++
 tb/tb_dm_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner states and the
// full-word load/store codes used by dm and the control unit.
package dm_arb_pkg;

  typedef enum logic [0:0] {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_e;

  localparam logic [2:0] LD_W = 3'b000;
  localparam logic [1:0] SV_W = 2'b00;

endpackage

// File: rtl/dm_arbiter.sv
// Arbitrates the single data memory between the CPU (default owner,
// zero-latency pass-through) and a word-wide DMA/debug-loader port.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW      = 7,
  parameter int unsigned DW      = 32,
  parameter int unsigned STARVE  = 8,
  parameter int unsigned DMA_RUN = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [2:0]    cpu_ld,
  input  logic [1:0]    cpu_sv,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic          dm_wr,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic [2:0]    dm_ld,
  output logic [1:0]    dm_sv,
  input  logic [DW-1:0] dm_dout
);

  localparam int unsigned WCW = $clog2(STARVE) + 1;
  localparam int unsigned RCW = $clog2(DMA_RUN) + 1;

  arb_state_e     r_state;
  arb_state_e     w_state_nxt;
  logic [WCW-1:0] r_wait_cnt;
  logic [RCW-1:0] r_run_cnt;
  logic [DW-1:0]  r_dma_rdata;
  logic           r_dma_rvalid;
  logic           w_wait_full;
  logic           w_run_full;
  logic           w_enter_dma;
  logic           w_dma_rd;

  assign w_wait_full = (r_wait_cnt == WCW'(STARVE - 1));
  assign w_run_full  = (r_run_cnt == RCW'(DMA_RUN - 1));
  assign w_enter_dma = (r_state == S_CPU) && (w_state_nxt == S_DMA);
  assign w_dma_rd    = (r_state == S_DMA) && dma_req && !dma_we;

  assign cpu_rdata  = dm_dout;
  assign dma_rdata  = r_dma_rdata;
  assign dma_rvalid = r_dma_rvalid;

  // Owner next-state and memory-port muxing
  always_comb begin
    w_state_nxt = r_state;
    dm_wr       = cpu_req & cpu_we;
    dm_addr     = cpu_addr;
    dm_din      = cpu_wdata;
    dm_ld       = cpu_ld;
    dm_sv       = cpu_sv;
    dma_gnt     = 1'b0;
    cpu_stall   = 1'b0;
    case (r_state)
      S_CPU: begin
        if (dma_req && (!cpu_req || w_wait_full)) w_state_nxt = S_DMA;
      end
      S_DMA: begin
        dm_wr     = dma_req & dma_we;
        dm_addr   = dma_addr;
        dm_din    = dma_wdata;
        dm_ld     = LD_W;
        dm_sv     = SV_W;
        dma_gnt   = dma_req;
        cpu_stall = cpu_req;
        if (!dma_req || (cpu_req && w_run_full)) w_state_nxt = S_CPU;
      end
      default: w_state_nxt = S_CPU;
    endcase
  end

  // State, starvation/run counters and registered DMA read data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_CPU;
      r_wait_cnt   <= '0;
      r_run_cnt    <= '0;
      r_dma_rdata  <= '0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_dma_rvalid <= w_dma_rd;
      if (w_dma_rd) r_dma_rdata <= dm_dout;
      if (w_enter_dma) begin
        r_wait_cnt <= '0;
        r_run_cnt  <= '0;
      end else begin
        if ((r_state == S_CPU) && dma_req && cpu_req && (r_wait_cnt != WCW'(STARVE)))
          r_wait_cnt <= r_wait_cnt + WCW'(1);
        // Holding at DMA_RUN-1 lets a CPU request that arrives late in a long
        // uncontested burst end it after one more grant.
        if (dma_gnt && !w_run_full)
          r_run_cnt <= r_run_cnt + RCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus a randomized
// phase, compared every cycle against a behavioural ownership/memory model.
module tb_dm_arbiter;

  localparam int unsigned AW      = 7;
  localparam int unsigned DW      = 32;
  localparam int          STARVE  = 8;
  localparam int          DMA_RUN = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [2:0]    cpu_ld;
  logic [1:0]    cpu_sv;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_din;
  logic [2:0]    dm_ld;
  logic [1:0]    dm_sv;
  logic [DW-1:0] dm_dout;

  int total = 0;
  int bad   = 0;

  dm_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE), .DMA_RUN(DMA_RUN)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ld(cpu_ld), .cpu_sv(cpu_sv), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din), .dm_ld(dm_ld), .dm_sv(dm_sv),
    .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  // Word memory standing in for dm: combinational read, write on rising edge
  logic [DW-1:0] mem [128];
  bit mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (dm_wr) begin
      mem[dm_addr] <= dm_din;
    end
  end
  assign dm_dout = mem[dm_addr];

  // Reference model: who owns memory, how long DMA has been held off, grants in the burst
  bit            m_dma_owner;
  int            m_waited;
  int            m_grants;
  logic [DW-1:0] ref_mem [128];
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  bit            last_gnt, last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dma_owner = 1'b0;
    m_waited    = 0;
    m_grants    = 0;
    m_rvalid    = 1'b0;
    m_rdata     = '0;
    last_gnt    = 1'b0;
    last_stall  = 1'b0;
  endtask

  // Check one cycle against the model, then advance across the clock edge
  task automatic tick();
    logic          e_gnt, e_stall, e_wr, rd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic [2:0]    e_ld;
    logic [1:0]    e_sv;
    #2;
    if (m_dma_owner) begin
      e_gnt = dma_req; e_stall = cpu_req; e_wr = dma_req & dma_we;
      e_addr = dma_addr; e_din = dma_wdata; e_ld = 3'b000; e_sv = 2'b00;
    end else begin
      e_gnt = 1'b0; e_stall = 1'b0; e_wr = cpu_req & cpu_we;
      e_addr = cpu_addr; e_din = cpu_wdata; e_ld = cpu_ld; e_sv = cpu_sv;
    end
    chk("dma_gnt", 32'(dma_gnt), 32'(e_gnt));
    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("dm_wr", 32'(dm_wr), 32'(e_wr));
    chk("dm_addr", 32'(dm_addr), 32'(e_addr));
    chk("dm_din", dm_din, e_din);
    chk("dm_ld", 32'(dm_ld), 32'(e_ld));
    chk("dm_sv", 32'(dm_sv), 32'(e_sv));
    chk("cpu_rdata", cpu_rdata, ref_mem[e_addr]);
    chk("dma_rvalid", 32'(dma_rvalid), 32'(m_rvalid));
    chk("dma_rdata", dma_rdata, m_rdata);
    last_gnt   = e_gnt;
    last_stall = e_stall;
    @(posedge clk);
    #1;
    rd = m_dma_owner && dma_req && !dma_we;
    m_rvalid = rd;
    if (rd) m_rdata = ref_mem[dma_addr];
    if (e_wr) ref_mem[e_addr] = e_din;
    if (!m_dma_owner) begin
      if (dma_req && (!cpu_req || m_waited >= STARVE - 1)) begin
        m_dma_owner = 1'b1; m_waited = 0; m_grants = 0;
      end else if (dma_req && cpu_req) begin
        m_waited++;
      end
    end else begin
      if (!dma_req || (cpu_req && m_grants >= DMA_RUN - 1)) m_dma_owner = 1'b0;
      else m_grants++;
    end
  endtask

  initial begin
    int n, g, granted, first_c, last_c, cyc, after_cpu;
    logic [DW-1:0] saved;
    bit cpu_on;

    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    model_reset();
    rstn = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_ld = 3'b000; cpu_sv = 2'b00;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;

    #2;
    chk("reset_gnt", 32'(dma_gnt), 32'd0);
    chk("reset_stall", 32'(cpu_stall), 32'd0);
    chk("reset_rvalid", 32'(dma_rvalid), 32'd0);
    chk("reset_rdata", dma_rdata, 32'd0);
    chk("reset_dm_wr", 32'(dm_wr), 32'd0);
    #10;
    rstn = 1'b1;
    mem_clr = 1'b0;
    @(posedge clk);
    #1;

    // Idle-gap DMA write of word 5
    dma_req = 1; dma_we = 1; dma_addr = 7'd5; dma_wdata = 32'hDEADBEEF;
    #1; chk("idle_gnt_c1", 32'(dma_gnt), 32'd0);
    tick();
    #1; chk("idle_gnt_c2", 32'(dma_gnt), 32'd1);
    tick();
    dma_req = 0; dma_we = 0;
    tick();

    // CPU lw of word 5
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'd5;
    #1; chk("cpu_lw5", cpu_rdata, 32'hDEADBEEF);
    tick();
    cpu_req = 0;

    // DMA read of word 5
    dma_req = 1; dma_we = 0; dma_addr = 7'd5;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (dma_gnt) break;
      tick();
    end
    chk("rd_gnt_seen", 32'(dma_gnt), 32'd1);
    chk("rd_rvalid_in_gnt", 32'(dma_rvalid), 32'd0);
    tick();
    dma_req = 0;
    #1;
    chk("rd_rvalid_pulse", 32'(dma_rvalid), 32'd1);
    chk("rd_rdata", dma_rdata, 32'hDEADBEEF);
    tick();
    #1; chk("rd_rvalid_drop", 32'(dma_rvalid), 32'd0);
    tick();

    // Starvation under continuous CPU traffic
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'd9;
    dma_req = 1; dma_we = 0; dma_addr = 7'd5;
    n = 0;
    while (n < 20) begin
      #1;
      if (dma_gnt) break;
      n++;
      tick();
    end
    chk("starve_cpu_cycles", 32'(n), 32'(STARVE));
    g = 0;
    for (int k = 0; k < 10; k++) begin
      if (!dma_gnt) break;
      chk("starve_stall", 32'(cpu_stall), 32'd1);
      g++;
      tick();
      #1;
    end
    chk("starve_run", 32'(g), 32'(DMA_RUN));
    chk("starve_resume", 32'(cpu_stall), 32'd0);
    dma_req = 0;
    tick();
    cpu_req = 0;
    tick();

    // Uncontested 10-word burst, then a burst interrupted by the CPU
    for (int b = 0; b < 2; b++) begin
      dma_req = 1; dma_we = 1; dma_addr = 7'(20 + 20 * b); dma_wdata = $urandom;
      granted = 0; first_c = -1; last_c = -1; cyc = 0; cpu_on = 0; after_cpu = 0;
      while (granted < 10 && cyc < 100) begin
        #1;
        if (cpu_on && !cpu_stall && after_cpu >= 0) begin
          chk("run_bound_grants", 32'(after_cpu <= DMA_RUN), 32'd1);
          after_cpu = -1;
        end
        if (dma_gnt) begin
          granted++;
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
          if (cpu_on && after_cpu >= 0) after_cpu++;
        end
        tick();
        cyc++;
        if (last_gnt) begin
          if (granted < 10) begin
            dma_addr = dma_addr + 7'd1; dma_wdata = $urandom;
          end else begin
            dma_req = 0;
          end
        end
        if (b == 1 && granted == 6 && !cpu_on) begin
          cpu_on = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 7'd20;
        end else if (cpu_on && !last_stall) begin
          cpu_addr = 7'(20 + $urandom_range(0, 9));
        end
      end
      chk("burst_all_granted", 32'(granted), 32'd10);
      if (b == 0) chk("burst_consecutive", 32'(last_c - first_c + 1), 32'd10);
      else chk("run_cpu_served", 32'(after_cpu), 32'hFFFF_FFFF);
      dma_req = 0; cpu_req = 0;
      tick();
    end

    // CPU sb pass-through
    cpu_req = 1; cpu_we = 1; cpu_addr = 7'd9; cpu_wdata = 32'h0000_00A5;
    cpu_sv = 2'b10; cpu_ld = 3'b011;
    #1;
    chk("sb_dm_sv", 32'(dm_sv), 32'(2'b10));
    chk("sb_dm_addr", 32'(dm_addr), 32'd9);
    chk("sb_dm_wr", 32'(dm_wr), 32'd1);
    tick();
    cpu_req = 0; cpu_we = 0; cpu_sv = 2'b00; cpu_ld = 3'b000;
    tick();

    // Randomized traffic obeying the requester rules
    for (int c = 0; c < 1500; c++) begin
      if (last_gnt || !dma_req) begin
        if ($urandom_range(0, 99) < 35) begin
          dma_req = 1; dma_we = 1'($urandom); dma_addr = 7'($urandom_range(0, 15));
          dma_wdata = $urandom;
        end else begin
          dma_req = 0;
        end
      end
      if (!last_stall) begin
        cpu_req = ($urandom_range(0, 99) < 60); cpu_we = 1'($urandom);
        cpu_addr = 7'($urandom_range(0, 15)); cpu_wdata = $urandom;
        cpu_ld = 3'($urandom); cpu_sv = 2'($urandom);
      end
      tick();
    end
    dma_req = 0; cpu_req = 0;
    tick();
    tick();

    // Reset asserted in the middle of a DMA burst
    dma_req = 1; dma_we = 0; dma_addr = 7'd3;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (dma_gnt) break;
      tick();
    end
    tick();
    dma_we = 1; dma_wdata = 32'hA5A5_0000;
    saved = ref_mem[3];
    #1;
    chk("rst_pre_gnt", 32'(dma_gnt), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst_gnt", 32'(dma_gnt), 32'd0);
    chk("rst_rvalid", 32'(dma_rvalid), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_dm_wr", 32'(dm_wr), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_no_write", mem[3], saved);
    model_reset();
    dma_req = 0; dma_we = 0;
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
